// File: rtl/spike_out_sequencer.sv
// Per-timestep spike-out sequencer: scans every neuron over req/ack and commits the vector with one write strobe while the bus is idle.
// Optional feature: define SPIKE_COUNT_EN to add spike_count_o, the number of spiking neurons in the last scan.
module spike_out_sequencer #(
  parameter int NUM_NEURONS = 256,
  parameter int IDX_W       = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   timestep_start_i,
  input  logic                   wbs_cyc_i,
  output logic                   neuron_req_o,
  output logic [IDX_W-1:0]       neuron_idx_o,
  input  logic                   neuron_ack_i,
  input  logic                   neuron_spike_i,
  output logic [NUM_NEURONS-1:0] spike_data_o,
  output logic                   spike_write_en_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overrun_o
`ifdef SPIKE_COUNT_EN
  ,
  output logic [IDX_W:0]         spike_count_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT,
    S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_NEURONS-1:0] data_q, data_d;
  logic                   write_en;
`ifdef SPIKE_COUNT_EN
  logic [IDX_W:0]         count_q, count_d;
`endif

  // NOTE: every variable gets its default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    write_en = 1'b0;
`ifdef SPIKE_COUNT_EN
    count_d  = count_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (timestep_start_i) begin
          data_d  = '0;
          idx_d   = '0;
          state_d = S_SCAN;
`ifdef SPIKE_COUNT_EN
          count_d = '0;
`endif
        end
      end
      S_SCAN: begin
        if (neuron_ack_i) begin
          data_d[idx_q] = neuron_spike_i;
`ifdef SPIKE_COUNT_EN
          if (neuron_spike_i) count_d = count_q + (IDX_W+1)'(1);
`endif
          // Compare against the last real index so a full 2**IDX_W scan never wraps.
          if (idx_q == LAST_IDX) state_d = S_COMMIT;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_COMMIT: begin
        if (!wbs_cyc_i) begin
          write_en = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef SPIKE_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
`ifdef SPIKE_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

  // Strobe and overrun are combinational; gating with reset keeps an abort from leaking a write.
  assign busy_o           = (state_q != S_IDLE);
  assign neuron_req_o     = (state_q == S_SCAN);
  assign neuron_idx_o     = idx_q;
  assign done_o           = (state_q == S_DONE);
  assign spike_write_en_o = write_en & ~wb_rst_i;
  assign overrun_o        = timestep_start_i & busy_o & ~wb_rst_i;
  assign spike_data_o     = data_q;
`ifdef SPIKE_COUNT_EN
  assign spike_count_o    = count_q;
`endif

endmodule
